// File: rtl/dual_port_ram_if.sv
// Bus bundle for the two independent read/write ports of dual_port_ram.
// The master drives address/data/enable; the slave (the RAM) returns registered read data.
interface dual_port_ram_if #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] data_in1;
  logic [DATA_WIDTH-1:0] data_out1;
  logic                  we2;
  logic [ADDR_WIDTH-1:0] addr2;
  logic [DATA_WIDTH-1:0] data_in2;
  logic [DATA_WIDTH-1:0] data_out2;

  modport master (
    output we1, addr1, data_in1,
    output we2, addr2, data_in2,
    input  data_out1, data_out2
  );

  modport slave (
    input  we1, addr1, data_in1,
    input  we2, addr2, data_in2,
    output data_out1, data_out2
  );
endinterface

// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM with registered, read-first outputs on both ports.
// Reset clears only the output registers; the array keeps its contents.
module dual_port_ram #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  dual_port_ram_if.slave  bus
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [Depth];
  logic [DATA_WIDTH-1:0] r_dout1;
  logic [DATA_WIDTH-1:0] r_dout2;

  // Array has no reset so it maps onto block RAM; writes are suppressed while in reset.
  // Port 2 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (bus.we1) r_mem[bus.addr1] <= bus.data_in1;
      if (bus.we2) r_mem[bus.addr2] <= bus.data_in2;
    end
  end

  // Non-blocking semantics sample the pre-write contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout1 <= '0;
      r_dout2 <= '0;
    end else begin
      r_dout1 <= r_mem[bus.addr1];
      r_dout2 <= r_mem[bus.addr2];
    end
  end

  assign bus.data_out1 = r_dout1;
  assign bus.data_out2 = r_dout2;

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed self-checking bench for dual_port_ram: read-first, cross-port,
// collision and reset-retention vectors with hand-computed expected values.
module tb_dual_port_ram;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 8;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  dual_port_ram_if #(AW, DW) bus ();

  dual_port_ram #(AW, DW) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] got,
                          input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  // Present one cycle of stimulus, take the edge, then settle before sampling.
  task automatic step(input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic w2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
    bus.we1      = w1;
    bus.addr1    = a1;
    bus.data_in1 = d1;
    bus.we2      = w2;
    bus.addr2    = a2;
    bus.data_in2 = d2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    step(1'b0, '0, '0, 1'b0, '0, '0);
    check_eq("reset_out1", bus.data_out1, 8'h00);
    check_eq("reset_out2", bus.data_out2, 8'h00);
    rst_n = 1'b1;

    // Dual write
    step(1'b1, 15'h1234, 8'h56, 1'b1, 15'h3456, 8'h56);
    step(1'b1, 15'h5678, 8'h9a, 1'b1, 15'h7891, 8'h9a);

    // Read-back, data_in left as X while not writing
    step(1'b0, 15'h1234, 'x, 1'b0, 15'h3456, 'x);
    check_eq("rb_1234", bus.data_out1, 8'h56);
    check_eq("rb_3456", bus.data_out2, 8'h56);
    step(1'b0, 15'h5678, 'x, 1'b0, 15'h7891, 'x);
    check_eq("rb_5678", bus.data_out1, 8'h9a);
    check_eq("rb_7891", bus.data_out2, 8'h9a);

    // Read-first on write
    step(1'b1, 15'h5678, 8'h03, 1'b1, 15'h3456, 8'h03);
    check_eq("rfw_old1", bus.data_out1, 8'h9a);
    check_eq("rfw_old2", bus.data_out2, 8'h56);
    step(1'b0, 15'h5678, 'x, 1'b0, 15'h3456, 'x);
    check_eq("rfw_new1", bus.data_out1, 8'h03);
    check_eq("rfw_new2", bus.data_out2, 8'h03);

    // Cross-port: p1 writes while p2 reads the same address
    step(1'b1, 15'h0100, 8'h11, 1'b0, 15'h0000, 'x);
    step(1'b1, 15'h0100, 8'haa, 1'b0, 15'h0100, 'x);
    check_eq("xp_old2", bus.data_out2, 8'h11);
    check_eq("xp_old1", bus.data_out1, 8'h11);
    step(1'b0, 15'h1234, 'x, 1'b0, 15'h0100, 'x);
    check_eq("xp_new2", bus.data_out2, 8'haa);

    // Collision: both ports write 0x0200, port 2 wins, both read old value
    step(1'b1, 15'h0200, 8'h77, 1'b0, 15'h0000, 'x);
    step(1'b1, 15'h0200, 8'h01, 1'b1, 15'h0200, 8'h02);
    check_eq("col_old1", bus.data_out1, 8'h77);
    check_eq("col_old2", bus.data_out2, 8'h77);
    step(1'b0, 15'h0200, 'x, 1'b0, 15'h0200, 'x);
    check_eq("col_new1", bus.data_out1, 8'h02);
    check_eq("col_new2", bus.data_out2, 8'h02);

    // Reset blocks writes and clears outputs but keeps array contents
    rst_n = 1'b0;
    step(1'b1, 15'h1234, 8'hff, 1'b0, 15'h0200, 'x);
    check_eq("rst_out1", bus.data_out1, 8'h00);
    check_eq("rst_out2", bus.data_out2, 8'h00);
    rst_n = 1'b1;
    step(1'b0, 15'h1234, 'x, 1'b0, 15'h1234, 'x);
    check_eq("ret_1234_p1", bus.data_out1, 8'h56);
    check_eq("ret_1234_p2", bus.data_out2, 8'h56);

    // Output holds across an edge only when address is unchanged; re-read a distinct word
    step(1'b0, 15'h7891, 'x, 1'b0, 15'h0100, 'x);
    check_eq("final_7891", bus.data_out1, 8'h9a);
    check_eq("final_0100", bus.data_out2, 8'haa);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
- True dual-port synchronous RAM backing the 6502 core's memory space.
- Two independent read/write ports share one clock and one storage array.
- Reads are registered and read-first: a write cycle on a port still returns that address's previous contents.
- The core relies on this to read and write in back-to-back cycles.

Parameters:
- ADDR_WIDTH, 15, address bits per port; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, bits per word.
- Both are positional in that order, so the instance form is #(15, 8).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous and active-low; clears output registers only.
- we1  input  1  port 1 write enable.
- addr1  input  ADDR_WIDTH  port 1 word address.
- data_in1  input  DATA_WIDTH  port 1 write data.
- data_out1  output  DATA_WIDTH  port 1 registered read data.
- we2  input  1  port 2 write enable.
- addr2  input  ADDR_WIDTH  port 2 word address.
- data_in2  input  DATA_WIDTH  port 2 write data.
- data_out2  output  DATA_WIDTH  port 2 registered read data.

Behaviour:
- Storage: 2**ADDR_WIDTH words of DATA_WIDTH bits.
  - Contents are undefined at power-up (X in simulation).
  - Reset does not clear the array.
- Reset, at a rising edge with rst_n=0:
  - data_out1 and data_out2 load 0.
  - No write occurs regardless of we1/we2.
  - The array is untouched.
- Normal operation, per port p, at each rising edge with rst_n=1:
  - data_outp <= mem[addrp], sampled before any write at this edge (read-first).
  - If wep=1, mem[addrp] <= data_inp.
- Read latency is one cycle.
  - data_outp reflects the address presented at the preceding rising edge.
  - It holds until the next edge.
- A written value is visible on either port for a read presented at the next edge or later.
- data_in is ignored (may be X) when we=0.
- Cross-port same address, same cycle, one port writing: the other port's read returns the old value.
- Both ports write the same address in the same cycle: port 2's data wins.
  - Both data_out registers return the old value.
- Addresses are exactly ADDR_WIDTH bits; there is no out-of-range case.
- No handshake and no stall: the RAM accepts one access per port per cycle, always.
- Implementation:
  - Must infer block RAM (registered outputs, read-first mode).
  - No combinational path from any input to data_out.

Test Plan:
- Dual write: cycle 1 writes 0x56 via port 1 at 0x1234 and via port 2 at 0x3456. Cycle 2 writes 0x9a via port 1 at 0x5678 and via port 2 at 0x7891.
- Read-back (continues from dual write): read 0x1234 and 0x3456 with we=0 -> after the edge, both outputs are 0x56. Then read 0x5678 and 0x7891 -> both outputs are 0x9a.
- Read-first on write (continues from read-back): write 0x03 via port 1 at 0x5678 and via port 2 at 0x3456 -> after that edge, data_out1=0x9a and data_out2=0x56. The next read of the same addresses returns 0x03 on both ports.
- Cross-port: port 1 writes 0xAA at 0x0100 while port 2 reads 0x0100 (holding 0x11) -> data_out2=0x11. Next cycle, port 2 reads 0x0100 -> 0xAA.
- Collision: both ports write 0x0200 (port 1 data 0x01, port 2 data 0x02) -> a subsequent read on either port returns 0x02.
- Reset:
  - Drive rst_n=0 for one edge with we1=1 at 0x1234, data 0xFF -> both outputs 0.
  - After releasing reset, reading 0x1234 returns its prior value (0x56 when run after the dual-write scenario) -> contents retained, and the write issued during reset did not land.
